// File: rtl/conv_maxpool.sv
// 2x2 / stride-2 max pooling over a row-major N x N stream of unsigned samples.
// One row of pair maxima is parked in a line buffer until the odd row completes each window.
module conv_maxpool #(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          done
);

  localparam int unsigned CW  = (N > 2) ? $clog2(N) : 1;
  localparam int unsigned LBW = (CW > 1) ? CW - 1 : 1;
  localparam int unsigned LBD = 2 ** LBW;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;
  logic [DW-1:0] hold_q, hold_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] linebuf_q [LBD];

  logic          xfer;
  logic          last_in;
  logic          lb_we;
  logic          emit;
  logic [LBW-1:0] lb_idx;
  logic [DW-1:0] pair_max;
  logic [DW-1:0] win_max;

  always_comb begin
    lb_idx   = LBW'(col_q >> 1);
    pair_max = (in_data > hold_q) ? in_data : hold_q;
    win_max  = (linebuf_q[lb_idx] > pair_max) ? linebuf_q[lb_idx] : pair_max;
    // Ready depends only on registered state, never on in_valid.
    in_ready = rst & (state_q == S_RUN) & (~out_valid_q | out_ready);
    xfer     = in_valid & in_ready;
    last_in  = xfer & (row_q == LAST) & (col_q == LAST);
    // Odd N: the trailing even row/column never reach an odd/odd slot, so they drop out.
    lb_we    = xfer & col_q[0] & ~row_q[0];
    emit     = xfer & col_q[0] & row_q[0];
  end

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    hold_d = hold_q;
    if (xfer) begin
      if (!col_q[0]) begin
        hold_d = in_data;
      end
      if (col_q == LAST) begin
        col_d = '0;
        row_d = (row_q == LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (emit) begin
      out_valid_d = 1'b1;
      out_data_d  = win_max;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (last_in) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!out_valid_q || out_ready) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = rst;
        state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_RUN;
      col_q       <= '0;
      row_q       <= '0;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      hold_q      <= hold_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (lb_we) begin
      linebuf_q[lb_idx] <= pair_max;
    end
  end

  assign out_valid = rst & out_valid_q;
  assign out_data  = rst ? out_data_q : '0;

endmodule

// File: tb/tb_conv_maxpool.sv
// Bench for conv_maxpool: an N=4 and an N=3 instance driven with directed and random
// frames, outputs scored against window maxima computed straight from each frame.
module tb_conv_maxpool;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_done;
  logic [15:0] a_in_data, a_out_data;
  logic        b_rst, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_done;
  logic [15:0] b_in_data, b_out_data;

  conv_maxpool #(.N(4), .DW(16)) dut_a (
    .clk(clk), .rst(a_rst), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .done(a_done)
  );

  conv_maxpool #(.N(3), .DW(16)) dut_b (
    .clk(clk), .rst(b_rst), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .done(b_done)
  );

  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];
  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;
  int a_done_cnt = 0;
  int b_done_cnt = 0;
  int last_wait = 0;
  bit rand_rdy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] max2(input logic [15:0] x, input logic [15:0] y);
    return (x > y) ? x : y;
  endfunction

  // Reference: each pooled value is the max of its 2x2 window, floor pooling for odd n.
  task automatic push_expect(input bit b, input int n, input logic [15:0] f[$]);
    for (int pr = 0; pr < n / 2; pr++) begin
      for (int pc = 0; pc < n / 2; pc++) begin
        logic [15:0] m;
        m = max2(max2(f[2*pr*n + 2*pc], f[2*pr*n + 2*pc + 1]),
                 max2(f[(2*pr+1)*n + 2*pc], f[(2*pr+1)*n + 2*pc + 1]));
        if (b) exp_b.push_back(m);
        else   exp_a.push_back(m);
      end
    end
  endtask

  always @(negedge clk) begin
    if (a_done) a_done_cnt++;
    if (b_done) b_done_cnt++;
    if (a_out_valid && a_out_ready) begin
      if (exp_a.size() == 0) chk("a_extra_out", 32'(a_out_data), 32'hFFFF_FFFF);
      else chk("a_out", 32'(a_out_data), 32'(exp_a.pop_front()));
    end
    if (b_out_valid && b_out_ready) begin
      if (exp_b.size() == 0) chk("b_extra_out", 32'(b_out_data), 32'hFFFF_FFFF);
      else chk("b_out", 32'(b_out_data), 32'(exp_b.pop_front()));
    end
  end

  // Called and returns at posedge+1; drops valid after the transfer edge.
  task automatic send(input bit b, input logic [15:0] d, input int gap);
    int waited;
    repeat (gap) begin
      if (b) b_in_valid = 1'b0; else a_in_valid = 1'b0;
      @(posedge clk); #1;
    end
    if (b) begin b_in_valid = 1'b1; b_in_data = d; end
    else   begin a_in_valid = 1'b1; a_in_data = d; end
    waited = 0;
    forever begin
      @(negedge clk);
      if (b ? b_in_ready : a_in_ready) break;
      waited++;
      if (waited > 500) begin
        $display("FAIL send_timeout: observed=stalled expected=in_ready within 500 cycles");
        $fatal(1);
      end
    end
    @(posedge clk); #1;
    if (b) b_in_valid = 1'b0; else a_in_valid = 1'b0;
    last_wait = waited;
  endtask

  task automatic send_frame(input bit b, input logic [15:0] f[$], input int maxgap);
    foreach (f[i]) send(b, f[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  task automatic finish_frame(input bit b, input string tag, input int dbefore);
    int cyc = 0;
    while (((b ? b_done_cnt : a_done_cnt) != dbefore + 1) && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    chk({tag, "_done_cnt"}, b ? b_done_cnt : a_done_cnt, dbefore + 1);
    chk({tag, "_drained"}, b ? exp_b.size() : exp_a.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=still running expected=finished");
    $fatal(1);
  end

  initial begin
    logic [15:0] f[$];
    int d0, tw;

    a_rst = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
    b_rst = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_out_valid", a_out_valid, 0);
    chk("rst_a_out_data", a_out_data, 0);
    chk("rst_a_done", a_done, 0);
    chk("rst_a_in_ready", a_in_ready, 0);
    chk("rst_b_out_valid", b_out_valid, 0);
    chk("rst_b_in_ready", b_in_ready, 0);
    @(posedge clk); #1;
    a_rst = 1'b1; b_rst = 1'b1;

    // Ascending 1..16, always ready
    f = {};
    for (int i = 1; i <= 16; i++) f.push_back(16'(i));
    push_expect(0, 4, f);
    d0 = a_done_cnt; tw = 0;
    foreach (f[i]) begin send(0, f[i], 0); tw += last_wait; end
    @(negedge clk);
    chk("t1_last_valid", a_out_valid, 1);
    chk("t1_last_data", a_out_data, 16);
    chk("t1_no_early_done", a_done, 0);
    chk("t1_drain_not_ready", a_in_ready, 0);
    @(negedge clk);
    chk("t1_done_pulse", a_done, 1);
    chk("t1_done_not_ready", a_in_ready, 0);
    @(negedge clk);
    chk("t1_done_cleared", a_done, 0);
    chk("t1_ready_again", a_in_ready, 1);
    chk("t1_never_stalled", tw, 0);
    finish_frame(0, "t1", d0);

    // Descending and saturated mixes
    f = {};
    for (int i = 16; i >= 1; i--) f.push_back(16'(i));
    push_expect(0, 4, f);
    d0 = a_done_cnt;
    send_frame(0, f, 0);
    finish_frame(0, "t2_desc", d0);
    f = {};
    for (int i = 0; i < 16; i++) f.push_back(($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h0000);
    push_expect(0, 4, f);
    d0 = a_done_cnt;
    send_frame(0, f, 0);
    finish_frame(0, "t2_sat", d0);

    // Backpressure on the first output
    f = {};
    for (int i = 1; i <= 16; i++) f.push_back(16'(i));
    push_expect(0, 4, f);
    d0 = a_done_cnt;
    a_out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(0, f[i], 0);
    a_in_valid = 1'b1; a_in_data = f[6];
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t3_stall_in_ready", a_in_ready, 0);
      chk("t3_stall_valid", a_out_valid, 1);
      chk("t3_stall_data", a_out_data, 6);
      @(posedge clk); #1;
    end
    a_out_ready = 1'b1;
    for (int i = 6; i < 16; i++) send(0, f[i], 0);
    finish_frame(0, "t3", d0);

    // Reset mid-frame, then a clean frame
    d0 = a_done_cnt;
    for (int i = 0; i < 6; i++) send(0, f[i], 0);
    a_rst = 1'b0;
    @(negedge clk);
    chk("t5_rst_valid", a_out_valid, 0);
    chk("t5_rst_data", a_out_data, 0);
    chk("t5_rst_done", a_done, 0);
    chk("t5_rst_in_ready", a_in_ready, 0);
    @(posedge clk); #1;
    a_rst = 1'b1;
    push_expect(0, 4, f);
    send_frame(0, f, 0);
    finish_frame(0, "t5", d0);

    // Odd N on the second instance
    f = {};
    for (int i = 1; i <= 9; i++) f.push_back(16'(i));
    push_expect(1, 3, f);
    d0 = b_done_cnt;
    send_frame(1, f, 0);
    @(negedge clk);
    chk("t4_drain_not_ready", b_in_ready, 0);
    chk("t4_drain_no_done", b_done, 0);
    chk("t4_drain_no_valid", b_out_valid, 0);
    @(negedge clk);
    chk("t4_done_pulse", b_done, 1);
    chk("t4_done_not_ready", b_in_ready, 0);
    @(negedge clk);
    chk("t4_ready_again", b_in_ready, 1);
    chk("t4_done_cleared", b_done, 0);
    finish_frame(1, "t4", d0);

    // Random data, input gaps and output backpressure over two frames
    rand_rdy = 1'b1;
    fork
      begin
        while (rand_rdy) begin
          @(posedge clk); #1;
          a_out_ready = ($urandom_range(0, 1) == 1);
        end
        a_out_ready = 1'b1;
      end
      begin
        for (int fr = 0; fr < 2; fr++) begin
          f = {};
          for (int i = 0; i < 16; i++) f.push_back(16'($urandom()));
          push_expect(0, 4, f);
          d0 = a_done_cnt;
          send_frame(0, f, 3);
          finish_frame(0, "t6", d0);
        end
        rand_rdy = 1'b0;
      end
    join
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
